// File: rtl/risc16_pkg.sv
// Shared types and constants for the risc16 pipeline controller.
// Holds the controller state encoding, the fixed boundary-register indices
// and the default register-index width.
package risc16_pkg;

  // Controller states: normal flow, multicycle EX freeze, drain before halt, halted.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } pipe_state_e;

  // Boundary register indices: reg0 = IF/ID, reg1 = ID/EX, reg2 = first post-EX.
  localparam int IDX_ID      = 0;
  localparam int IDX_EX      = 1;
  localparam int IDX_POST_EX = 2;

  // Default register-index width (8 architectural registers, r0 hardwired zero).
  localparam int REG_AW_DEF  = 3;

endpackage

// File: rtl/risc16_mc_timer.sv
// Multicycle EX latency timer for the risc16 pipeline controller.
// Loads a remaining-cycle count, decrements on request and flags zero.
// The decrement saturates at zero so a stray request cannot wrap it.
module risc16_mc_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Counter register: load has priority over decrement.
  // NOTE: clocked state is written only with non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/risc16_pipe_ctrl.sv
// risc16 pipeline controller: stall, flush, bubble insertion, multicycle EX
// freeze and halt/drain/resume for a NUM_STAGES-deep pipeline.
// Drives the PC enable/load and the enables of the NUM_STAGES-1 boundary
// registers, and owns the valid bit carried by each of those registers.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined;
// otherwise the perf_* ports are tied to zero and no counter flops exist.
module risc16_pipe_ctrl
  import risc16_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int REG_AW     = REG_AW_DEF,
  parameter int MC_LAT_W   = 4,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid,
  input  logic [REG_AW-1:0]     id_rs1,
  input  logic [REG_AW-1:0]     id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_AW-1:0]     ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_br_taken,
  input  logic                  ex_mc_start,
  input  logic [MC_LAT_W-1:0]   ex_mc_lat,
  input  logic                  halt_req,
  input  logic                  resume_req,
  output logic                  pc_en,
  output logic                  pc_load,
  output logic [NUM_STAGES-2:0] pr_en,
  output logic [NUM_STAGES-2:0] pr_valid,
  output logic                  stall,
  output logic                  halted,
  output logic [PERF_W-1:0]     perf_cyc,
  output logic [PERF_W-1:0]     perf_stall,
  output logic [PERF_W-1:0]     perf_flush,
  output logic [PERF_W-1:0]     perf_ret
);

  localparam int NR = NUM_STAGES - 1;

  pipe_state_e         r_state;
  pipe_state_e         w_state_nxt;
  logic [NR-1:0]       r_valid;
  logic [NR-1:0]       w_valid_nxt;
  logic [NR-1:0]       w_upstream;
  logic [NR-1:0]       w_pr_en;
  logic [NR-1:0]       w_kill;
  logic                r_halt_pend;
  logic                w_halt_pend_nxt;

  logic                w_id_valid;
  logic                w_ex_valid;
  logic                w_fetch_on;
  logic                w_rs1_hit;
  logic                w_rs2_hit;
  logic                w_load_use;
  logic                w_flush;
  logic                w_mc_enter;
  logic                w_mc_hold;
  logic                w_mc_release;
  logic                w_mc_zero;
  logic                w_mc_load;
  logic                w_mc_dec;
  logic [MC_LAT_W-1:0] w_mc_load_val;
  logic                w_pc_en;
  logic                w_pc_load;

  assign w_id_valid = r_valid[IDX_ID];
  assign w_ex_valid = r_valid[IDX_EX];
  assign w_fetch_on = (r_state == RUN) || (r_state == MC_WAIT);

  // Load-use hazard: r0 is never a real destination, so ex_rd==0 cannot stall.
  assign w_rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
  assign w_rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
  assign w_load_use = w_ex_valid && ex_is_load && (ex_rd != '0) && w_id_valid &&
                      (w_rs1_hit || w_rs2_hit);

  // Redirect wins over everything, including a multicycle start in the same cycle.
  assign w_flush    = w_ex_valid && ex_br_taken && (r_state != HALTED);

  // Multicycle entry only from RUN; latency 0/1 completes without freezing.
  assign w_mc_enter    = (r_state == RUN) && w_ex_valid && ex_mc_start &&
                         (ex_mc_lat >= MC_LAT_W'(2)) && !w_flush;
  assign w_mc_hold     = (r_state == MC_WAIT) && !w_mc_zero && !w_flush;
  assign w_mc_release  = (r_state == MC_WAIT) && (w_mc_zero || w_flush);
  // Entry cycle is the first stall, so lat-2 remaining hold cycles follow it.
  assign w_mc_load_val = ex_mc_lat - MC_LAT_W'(2);

  risc16_mc_timer #(
    .CNT_W (MC_LAT_W)
  ) u_mc_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_mc_load),
    .i_load_val (w_mc_load_val),
    .i_dec      (w_mc_dec),
    .o_zero     (w_mc_zero)
  );

  // PC and boundary-register enables plus per-register kill (bubble) selects, by priority.
  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_pc_en   = w_fetch_on;
    w_pc_load = 1'b0;
    w_pr_en   = '1;
    w_kill    = '0;
    w_mc_load = 1'b0;
    w_mc_dec  = 1'b0;
    if (r_state == HALTED) begin
      w_pc_en = 1'b0;
      w_pr_en = '0;
    end else if (w_flush) begin
      w_pc_load      = 1'b1;
      w_pc_en        = 1'b1;
      w_kill[IDX_ID] = 1'b1;
      w_kill[IDX_EX] = 1'b1;
    end else if (w_mc_enter || w_mc_hold) begin
      w_pc_en             = 1'b0;
      w_pr_en[IDX_ID]     = 1'b0;
      w_pr_en[IDX_EX]     = 1'b0;
      w_kill[IDX_POST_EX] = 1'b1;
      w_mc_load           = w_mc_enter;
      w_mc_dec            = w_mc_hold;
    end else if (w_load_use) begin
      w_pc_en         = 1'b0;
      w_pr_en[IDX_ID] = 1'b0;
      w_kill[IDX_EX]  = 1'b1;
    end
  end

  // Valid shift chain: an enabled register takes its upstream valid unless killed.
  always_comb begin
    w_upstream  = {r_valid[NR-2:0], (if_valid && w_fetch_on)};
    w_valid_nxt = r_valid;
    for (int k = 0; k < NR; k++) begin
      if (w_pr_en[k]) begin
        w_valid_nxt[k] = w_upstream[k] && !w_kill[k];
      end
    end
  end

  // Next-state logic for RUN / MC_WAIT / DRAIN / HALTED and the pending-halt flag.
  always_comb begin
    w_state_nxt     = r_state;
    w_halt_pend_nxt = r_halt_pend;
    case (r_state)
      RUN: begin
        if (w_mc_enter) begin
          w_state_nxt     = MC_WAIT;
          w_halt_pend_nxt = halt_req;
        end else if (halt_req) begin
          w_state_nxt = DRAIN;
        end
      end
      MC_WAIT: begin
        if (halt_req) begin
          w_halt_pend_nxt = 1'b1;
        end
        if (w_mc_release) begin
          w_state_nxt = (r_halt_pend || halt_req) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        // Halt on the same edge that clears the last valid bit.
        if (w_valid_nxt == '0) begin
          w_state_nxt = HALTED;
        end
      end
      HALTED: begin
        if (resume_req) begin
          w_state_nxt     = RUN;
          w_halt_pend_nxt = 1'b0;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Controller state, valid bits and pending-halt flag; reset discards any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_valid     <= '0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_valid     <= w_valid_nxt;
      r_halt_pend <= w_halt_pend_nxt;
    end
  end

  assign pc_en    = w_pc_en;
  assign pc_load  = w_pc_load;
  assign pr_en    = w_pr_en;
  assign pr_valid = r_valid;
  assign stall    = !w_pc_en && !w_pc_load && w_fetch_on;
  assign halted   = (r_state == HALTED);

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_perf_cyc;
  logic [PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0] r_perf_flush;
  logic [PERF_W-1:0] r_perf_ret;

  // Free-running event counters; they wrap silently at 2^PERF_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cyc   <= '0;
      r_perf_stall <= '0;
      r_perf_flush <= '0;
      r_perf_ret   <= '0;
    end else begin
      if (r_state != HALTED) r_perf_cyc   <= r_perf_cyc   + PERF_W'(1);
      if (stall)             r_perf_stall <= r_perf_stall + PERF_W'(1);
      if (w_pc_load)         r_perf_flush <= r_perf_flush + PERF_W'(1);
      if (r_valid[NR-1])     r_perf_ret   <= r_perf_ret   + PERF_W'(1);
    end
  end

  assign perf_cyc   = r_perf_cyc;
  assign perf_stall = r_perf_stall;
  assign perf_flush = r_perf_flush;
  assign perf_ret   = r_perf_ret;
`else
  assign perf_cyc   = '0;
  assign perf_stall = '0;
  assign perf_flush = '0;
  assign perf_ret   = '0;
`endif

endmodule
